bus_burst_master: RTL and testbench
===================================

Name: bus_burst_master

Overview:
- Upstream master-port adapter between a cache/refill client and one master slot of the shared BusController.
- Converts single line requests (4 words, 128 bits, 16-byte aligned) into the controller's burst protocol: assert rreq/wreq, wait for master_acc, then drive 4 word addresses on consecutive cycles.
- Read bursts collect the 4 returned words into one line response; write bursts stream 4 words out.

Parameters:
READ_LATENCY, 2, cycles from presenting a read address on master_addr to the matching word being valid on master_rdata (legal 1..4)
TIMEOUT_CYCLES, 1024, grant-wait limit when BUS_MASTER_TIMEOUT_EN is defined

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  client line request valid
req_write  in  1  1 = writeback, 0 = refill
req_addr  in  32  line address; bits [3:0] ignored (treated as 0)
req_wline  in  128  write line; word k = bits [32k+31:32k]
req_ready  out  1  request accepted when req_valid & req_ready
resp_valid  out  1  one-cycle pulse: transaction complete
resp_rline  out  128  refill data; valid with resp_valid on reads, word k at [32k+31:32k]
resp_err  out  1  timeout flag, valid with resp_valid (0 when feature is off)
master_addr  out  32  bus word address
master_wdata  out  32  bus write data
master_rreq  out  1  bus read request
master_wreq  out  1  bus write request
master_acc  in  1  grant from BusController
master_rdata  in  32  bus read data

Behaviour:
- Reset (async): state IDLE. req_ready=1; resp_valid=0; resp_err=0; master_rreq=0; master_wreq=0; master_addr=0; master_wdata=0; resp_rline=0; beat and latency counters cleared.
- States: IDLE, WAIT_ACC, BURST, DRAIN, RESP.
- IDLE:
  - req_ready=1.
  - On handshake, latch address as {req_addr[31:4], 4'b0}, latch req_write and req_wline.
  - Assert master_rreq or master_wreq from the next cycle; req_ready=0; go to WAIT_ACC.
- WAIT_ACC:
  - Hold the request line high.
  - The first cycle master_acc is sampled 1, go to BURST with beat=0.
- BURST, beats 0..3, one beat per cycle:
  - master_addr = base + 4*beat.
  - Writes: master_wdata = word[beat]. After beat 3, deassert master_wreq and go to RESP.
  - Reads: master_rreq stays high through beat 2 and drops in the cycle beat 3 is presented. Go to DRAIN.
- DRAIN (reads only):
  - Word k is captured from master_rdata exactly READ_LATENCY cycles after the cycle address k was presented, into resp_rline[32k+31:32k].
  - Captures overlap BURST when READ_LATENCY < 4.
  - After word 3 is captured, go to RESP.
- RESP: resp_valid=1 for one cycle, then IDLE.
- req_ready=1 only in IDLE. No new request is accepted while busy.
- Latency:
  - Write: handshake to resp_valid = 1 + grant wait + 4 + 1 cycles.
  - Read: handshake to resp_valid = 1 + grant wait + 3 + READ_LATENCY + 1 cycles.
- master_addr keeps its last value outside BURST; master_wdata is 0 on reads.
- master_acc is ignored outside WAIT_ACC. Deassertion of master_acc mid-burst is ignored (the controller owns the bus until the request drops).
- resp_rline holds its value until the next read completes; write responses leave it unchanged.
- Changes to req_* after handshake have no effect.
- Reset mid-burst: all outputs return to reset values immediately. The in-flight transaction is dropped and no resp_valid is issued.
- Address wrap: base 0xFFFFFFF0 produces 0xFFFFFFF0, F4, F8, FC. No carry out.

Optional Feature:
- Macro: BUS_MASTER_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_ACC.
  - If master_acc is not seen within TIMEOUT_CYCLES cycles, drop rreq/wreq and go to RESP with resp_err=1. resp_rline is unchanged.
  - The counter clears on entering WAIT_ACC.
  - A grant and the timeout in the same cycle: the grant wins.
- Not defined: no counter is built, WAIT_ACC waits indefinitely, and resp_err is tied to 0.

Test Plan:
- Write req_addr=0x00001004, line words {0x11,0x22,0x33,0x44}, acc after 3 cycles -> master_wreq high 3 cycles before acc. Beats addr 0x1000/0x1004/0x1008/0x100C carry wdata 0x11/0x22/0x33/0x44. wreq drops after beat 3. resp_valid pulse with resp_err=0.
- Read 0x2000, READ_LATENCY=2, a memory model returns addr+1 -> resp_rline = {0x200D,0x2009,0x2005,0x2001}. rreq drops on beat 3. resp_valid exactly 6 cycles after acc.
- req_valid held high during a busy read -> req_ready=0 throughout. Second request is accepted in the cycle after resp_valid. Exactly two responses.
- Async reset pulse during beat 1 of a write -> wreq/rreq go to 0 without a clock edge. No resp_valid. Next request completes normally.
- Base 0xFFFFFFF0 read -> addresses F0/F4/F8/FC. READ_LATENCY=4 sweep gives correct word order.
- BUS_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, acc never asserted -> rreq drops after 16 cycles. resp_valid=1 with resp_err=1. resp_rline unchanged.

Source files
------------

// File: rtl/bus_burst_master.sv
// ----------------------------------------------------------------------------
// bus_burst_master
//   Upstream master-port adapter between a cache/refill client and one master
//   slot of the shared BusController. A 16-byte line request becomes a 4-beat
//   burst: raise rreq/wreq, wait for master_acc, then present the four word
//   addresses on consecutive cycles. Reads gather the four returned words into
//   one line response; writes stream the line out word by word.
//
// Parameters
//   READ_LATENCY   : clock edges from a read address being presented until
//                    the matching word is captured off master_rdata (1..4)
//   TIMEOUT_CYCLES : grant-wait limit, only used with the timeout option
//
// Optional feature
//   `define BUS_MASTER_TIMEOUT_EN : abandon a request whose grant does not
//   arrive within TIMEOUT_CYCLES; it completes with resp_err=1. Without the
//   macro no counter exists and resp_err is tied low.
//
// Ports
//   clk, reset            : clock (rising edge), async active-high reset
//   req_valid/req_ready   : client request handshake
//   req_write             : 1 = writeback, 0 = refill
//   req_addr              : line address, bits [3:0] ignored
//   req_wline             : write line, word k at [32k+31:32k]
//   resp_valid            : one-cycle completion pulse
//   resp_rline            : refill line, updated only when a read completes
//   resp_err              : timeout flag, qualified by resp_valid
//   master_addr/wdata     : bus word address / write data
//   master_rreq/wreq      : bus request lines, held until the burst ends
//   master_acc            : grant from the BusController
//   master_rdata          : bus read data
// ----------------------------------------------------------------------------
module bus_burst_master #(
    parameter int READ_LATENCY   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    input  logic         req_write,
    input  logic [31:0]  req_addr,
    input  logic [127:0] req_wline,
    output logic         req_ready,
    output logic         resp_valid,
    output logic [127:0] resp_rline,
    output logic         resp_err,
    output logic [31:0]  master_addr,
    output logic [31:0]  master_wdata,
    output logic         master_rreq,
    output logic         master_wreq,
    input  logic         master_acc,
    input  logic [31:0]  master_rdata
);

    if (READ_LATENCY < 1 || READ_LATENCY > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("bus_burst_master: READ_LATENCY must be 1..4 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {IDLE, WAIT_ACC, BURST, DRAIN, RESP} state_t;

    state_t         state, state_nxt;
    logic           wr_q;
    logic [27:0]    base_q;
    logic [127:0]   wline_q;
    logic [1:0]     beat, beat_nxt;
    logic [1:0]     cap_idx;
    logic [3:0]     rd_sr;
    logic [4:0]     vld_pipe;
    logic [95:0]    rline_buf;
    logic           handshake, issue, capture, last_cap, to_hit;
    logic           unused_addr_lsbs;

    assign unused_addr_lsbs = ^req_addr[3:0];

    assign handshake = (state == IDLE) && req_valid;
    assign beat_nxt  = beat + 2'd1;

    // A read address is on the bus this cycle. vld_pipe[i] marks that the
    // address went out i cycles ago; the word is captured at the end of the
    // cycle READ_LATENCY-1 after presentation, so with READ_LATENCY=1 the
    // capture coincides with the presenting cycle.
    assign issue    = (state == BURST) && !wr_q;
    assign vld_pipe = {rd_sr, issue};
    assign capture  = vld_pipe[READ_LATENCY-1];
    assign last_cap = capture && (cap_idx == 2'd3);

    assign req_ready   = (state == IDLE);
    assign resp_valid  = (state == RESP);
    assign master_wreq = wr_q && ((state == WAIT_ACC) || (state == BURST));
    // rreq drops while beat 3 is presented; the controller only needs it
    // high until the last address has been issued.
    assign master_rreq = !wr_q && ((state == WAIT_ACC) ||
                                   ((state == BURST) && (beat != 2'd3)));

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (req_valid) state_nxt = WAIT_ACC;
            WAIT_ACC: begin
                if (master_acc)  state_nxt = BURST;   // grant beats timeout
                else if (to_hit) state_nxt = RESP;
            end
            BURST: begin
                if (beat == 2'd3) begin
                    if (wr_q || last_cap) state_nxt = RESP;
                    else                  state_nxt = DRAIN;
                end
            end
            DRAIN:    if (last_cap) state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q         <= 1'b0;
            base_q       <= '0;
            wline_q      <= '0;
            beat         <= '0;
            cap_idx      <= '0;
            rd_sr        <= '0;
            rline_buf    <= '0;
            resp_rline   <= '0;
            master_addr  <= '0;
            master_wdata <= '0;
        end else begin
            rd_sr <= {rd_sr[2:0], issue};

            if (handshake) begin
                base_q  <= req_addr[31:4];
                wr_q    <= req_write;
                wline_q <= req_wline;
                cap_idx <= '0;
                if (!req_write) master_wdata <= '0;
            end

            if ((state == WAIT_ACC) && master_acc) begin
                beat         <= '0;
                master_addr  <= {base_q, 4'h0};
                master_wdata <= wr_q ? wline_q[31:0] : '0;
            end

            if (state == BURST) begin
                beat <= beat_nxt;
                // Last beat leaves address/data parked on the bus.
                if (beat != 2'd3) begin
                    master_addr  <= {base_q, beat_nxt, 2'b00};
                    master_wdata <= wr_q ? wline_q[{beat_nxt, 5'd0} +: 32] : '0;
                end
            end

            // Words 0..2 are staged so resp_rline changes only when the whole
            // line is in; word 3 goes straight into the response.
            if (capture) begin
                cap_idx <= cap_idx + 2'd1;
                case (cap_idx)
                    2'd0:    rline_buf[31:0]  <= master_rdata;
                    2'd1:    rline_buf[63:32] <= master_rdata;
                    2'd2:    rline_buf[95:64] <= master_rdata;
                    default: resp_rline       <= {master_rdata, rline_buf};
                endcase
            end
        end
    end

    // ------------------------------------------------------- grant timeout
`ifdef BUS_MASTER_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    assign to_hit   = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign resp_err = err_q && (state == RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else if (handshake) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else if (state == WAIT_ACC) begin
            to_cnt <= to_cnt + 1'b1;
            if (!master_acc && to_hit) err_q <= 1'b1;
        end
    end
`else
    assign to_hit   = 1'b0;
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_burst_master.sv
// ----------------------------------------------------------------------------
// tb_bus_burst_master
//   Directed bench for bus_burst_master. dut uses READ_LATENCY=2 and a 16-cycle
//   grant timeout; dut4 uses READ_LATENCY=4 and shares the request fields but
//   has its own req_valid/master_acc. Each bus is served by a small memory
//   model returning addr+1 with the configured latency.
// ----------------------------------------------------------------------------
module tb_bus_burst_master;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_write, acc;
    logic [31:0]  req_addr;
    logic [127:0] req_wline;
    logic         req_valid4, acc4;

    logic         req_ready, resp_valid, resp_err, m_rreq, m_wreq;
    logic [127:0] resp_rline;
    logic [31:0]  m_addr, m_wdata, m_rdata;

    logic         req_ready4, resp_valid4, resp_err4, m4_rreq, m4_wreq;
    logic [127:0] resp_rline4;
    logic [31:0]  m4_addr, m4_wdata, m4_rdata;

    logic [31:0]  m2_d1 = '0;
    logic [31:0]  m4_d1 = '0, m4_d2 = '0, m4_d3 = '0;

    int vectors = 0;
    int miscompares = 0;
    int resp_cnt = 0;
    int resp4_cnt = 0;
    int n;

    always #5 clk = ~clk;

    bus_burst_master #(.READ_LATENCY(2), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wline(req_wline), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rline(resp_rline), .resp_err(resp_err),
        .master_addr(m_addr), .master_wdata(m_wdata),
        .master_rreq(m_rreq), .master_wreq(m_wreq),
        .master_acc(acc), .master_rdata(m_rdata)
    );

    bus_burst_master #(.READ_LATENCY(4), .TIMEOUT_CYCLES(16)) dut4 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid4), .req_write(req_write), .req_addr(req_addr),
        .req_wline(req_wline), .req_ready(req_ready4),
        .resp_valid(resp_valid4), .resp_rline(resp_rline4), .resp_err(resp_err4),
        .master_addr(m4_addr), .master_wdata(m4_wdata),
        .master_rreq(m4_rreq), .master_wreq(m4_wreq),
        .master_acc(acc4), .master_rdata(m4_rdata)
    );

    // Memory models: word for an address presented in cycle c is on rdata in
    // cycle c + READ_LATENCY - 1.
    always @(posedge clk) begin
        m2_d1 <= m_addr;
        m4_d1 <= m4_addr;
        m4_d2 <= m4_d1;
        m4_d3 <= m4_d2;
    end
    assign m_rdata  = m2_d1 + 32'd1;
    assign m4_rdata = m4_d3 + 32'd1;

    always @(posedge clk) begin
        if (resp_valid)  resp_cnt  <= resp_cnt + 1;
        if (resp_valid4) resp4_cnt <= resp4_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; req_valid = 0; req_write = 0; req_addr = '0; req_wline = '0;
        acc = 0; req_valid4 = 0; acc4 = 0;
        #2;
        chk("rst_ready",  req_ready,  1);
        chk("rst_rvalid", resp_valid, 0);
        chk("rst_err",    resp_err,   0);
        chk("rst_rreq",   m_rreq,     0);
        chk("rst_wreq",   m_wreq,     0);
        chk("rst_addr",   m_addr,     0);
        chk("rst_wdata",  m_wdata,    0);
        chk("rst_rline",  resp_rline, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // ---- write 0x1004, grant after three waiting cycles
        req_valid = 1; req_write = 1; req_addr = 32'h1004;
        req_wline = {32'h44, 32'h33, 32'h22, 32'h11};
        tick();
        req_valid = 0; req_addr = 32'hDEAD0000; req_wline = '0;
        for (int i = 0; i < 3; i++) begin
            chk("wr_wait_wreq",  m_wreq,    1);
            chk("wr_wait_ready", req_ready, 0);
            tick();
        end
        chk("wr_wait_wreq", m_wreq, 1);
        acc = 1; tick(); acc = 0;
        for (int k = 0; k < 4; k++) begin
            chk("wr_beat_addr", m_addr,  32'h1000 + 32'(4 * k));
            chk("wr_beat_data", m_wdata, 32'h11 * 32'(k + 1));
            chk("wr_beat_wreq", m_wreq,  1);
            tick();
        end
        chk("wr_resp_valid", resp_valid, 1);
        chk("wr_resp_err",   resp_err,   0);
        chk("wr_resp_wreq",  m_wreq,     0);
        chk("wr_resp_rline", resp_rline, 0);
        tick();
        chk("wr_idle_valid", resp_valid, 0);
        chk("wr_idle_ready", req_ready,  1);
        chk("wr_addr_hold",  m_addr,     32'h100C);

        // ---- read 0x2000 with req_valid held; next request is 0x3008
        req_valid = 1; req_write = 0; req_addr = 32'h2000; req_wline = {4{32'hA5A5A5A5}};
        tick();
        req_addr = 32'h3008;
        chk("rd_wait_rreq",  m_rreq,    1);
        chk("rd_wait_wreq",  m_wreq,    0);
        chk("rd_wait_ready", req_ready, 0);
        acc = 1; tick(); acc = 0;
        for (int k = 0; k < 4; k++) begin
            chk("rd_beat_addr",  m_addr,    32'h2000 + 32'(4 * k));
            chk("rd_beat_rreq",  m_rreq,    (k < 3));
            chk("rd_beat_wdata", m_wdata,   0);
            chk("rd_beat_ready", req_ready, 0);
            tick();
        end
        chk("rd_drain_valid", resp_valid, 0);
        chk("rd_drain_rreq",  m_rreq,     0);
        chk("rd_drain_ready", req_ready,  0);
        tick();
        chk("rd_resp_valid", resp_valid, 1);
        chk("rd_resp_rline", resp_rline, 128'h0000200D_00002009_00002005_00002001);
        chk("rd_resp_ready", req_ready,  0);
        tick();
        chk("rd_idle_ready", req_ready,  1);
        chk("rd_idle_valid", resp_valid, 0);
        tick();
        req_valid = 0;
        chk("rd2_wait_rreq",  m_rreq,    1);
        chk("rd2_wait_ready", req_ready, 0);
        acc = 1; tick(); acc = 0;
        n = 0;
        while (!resp_valid && n < 20) begin tick(); n++; end
        chk("rd2_latency", n, 5);
        chk("rd2_rline",   resp_rline, 128'h0000300D_00003009_00003005_00003001);
        tick();
        chk("resp_count_3", resp_cnt, 3);

        // ---- async reset during beat 1 of a write
        req_valid = 1; req_write = 1; req_addr = 32'h4000;
        req_wline = {32'h4, 32'h3, 32'h2, 32'h1};
        tick();
        req_valid = 0; acc = 1; tick(); acc = 0;
        tick();
        chk("mid_wreq",  m_wreq,  1);
        chk("mid_addr",  m_addr,  32'h4004);
        chk("mid_wdata", m_wdata, 32'h2);
        #1 reset = 1'b1;
        #1;
        chk("arst_wreq",  m_wreq,     0);
        chk("arst_rreq",  m_rreq,     0);
        chk("arst_ready", req_ready,  1);
        chk("arst_addr",  m_addr,     0);
        chk("arst_wdata", m_wdata,    0);
        chk("arst_rline", resp_rline, 0);
        @(negedge clk);
        reset = 1'b0;
        tick(); tick();
        chk("arst_no_resp", resp_cnt, 3);

        req_valid = 1; req_write = 0; req_addr = 32'h5000;
        tick();
        req_valid = 0;
        tick();
        acc = 1; tick(); acc = 0;
        n = 0;
        while (!resp_valid && n < 20) begin tick(); n++; end
        chk("post_rst_latency", n, 5);
        chk("post_rst_rline",   resp_rline, 128'h0000500D_00005009_00005005_00005001);
        chk("post_rst_err",     resp_err, 0);
        tick();
        chk("resp_count_4", resp_cnt, 4);

        // ---- wrap-around read on the READ_LATENCY=4 instance
        req_valid4 = 1; req_write = 0; req_addr = 32'hFFFFFFF0;
        tick();
        req_valid4 = 0;
        acc4 = 1; tick(); acc4 = 0;
        for (int k = 0; k < 4; k++) begin
            chk("wrap_addr", m4_addr, 32'hFFFFFFF0 + 32'(4 * k));
            chk("wrap_rreq", m4_rreq, (k < 3));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk("rl4_early_valid", resp_valid4, 0);
            tick();
        end
        chk("rl4_resp_valid", resp_valid4, 1);
        chk("rl4_resp_rline", resp_rline4, 128'hFFFFFFFD_FFFFFFF9_FFFFFFF5_FFFFFFF1);
        chk("rl4_resp_err",   resp_err4,   0);
        tick();
        chk("rl4_count",      resp4_cnt, 1);
        chk("rl2_unaffected", resp_cnt,  4);

`ifdef BUS_MASTER_TIMEOUT_EN
        // ---- grant never arrives: abandoned after 16 waiting cycles
        req_valid = 1; req_write = 0; req_addr = 32'h6000;
        tick();
        req_valid = 0;
        for (int i = 0; i < 16; i++) begin
            chk("to_wait_rreq", m_rreq, 1);
            tick();
        end
        chk("to_rreq_drop", m_rreq,     0);
        chk("to_valid",     resp_valid, 1);
        chk("to_err",       resp_err,   1);
        chk("to_rline",     resp_rline, 128'h0000500D_00005009_00005005_00005001);
        tick();
        chk("to_idle_ready", req_ready, 1);
        chk("to_idle_err",   resp_err,  0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
